// File: rtl/tiger_avalon_pipelined_master_if.sv
// Avalon-MM bus bundle between the Tiger data master and its slave.
// The master drives the command; the slave drives the response and the stall.
interface tiger_avalon_pipelined_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  waitrequest;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/tiger_avalon_pipelined_master.sv
// Tiger core data master: pipelined Avalon-MM loads/stores with up to MAX_PENDING
// reads in flight, in-order return, lane extraction and sign/zero extension.
module tiger_avalon_pipelined_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_PENDING = 4,
  localparam int PW         = $clog2(MAX_PENDING) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_writedata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_readdata,
  output logic [PW-1:0]         pending_count,
  output logic                  err_misaligned,
  output logic                  err_protocol,
  tiger_avalon_pipelined_master_if.master avm
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OB       = $clog2(BE_WIDTH);
  localparam int PTR_W    = $clog2(MAX_PENDING);
  localparam int ENTRY_W  = OB + 3;

  // Command register
  logic [ADDR_WIDTH-1:0] address_reg;
  logic                  read_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] writedata_reg;
  logic [BE_WIDTH-1:0]   byteenable_reg;
  logic                  err_misaligned_reg;

  // Pending-load FIFO and response state
  logic [ENTRY_W-1:0]    fifo_mem [MAX_PENDING];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PW-1:0]         count_reg;
  logic                  ignore_stray_reg;
  logic                  err_protocol_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_readdata_reg;

  logic [OB-1:0]         size_mask;
  logic [OB-1:0]         off_raw;
  logic [OB-1:0]         off;
  logic                  misaligned;
  logic [7:0]            be_base;
  logic [15:0]           be_shifted;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic                  cmd_busy;
  logic                  full;
  logic                  pop;
  logic                  accept;
  logic                  push;

  logic [ENTRY_W-1:0]    head;
  logic [OB-1:0]         head_off;
  logic [1:0]            head_size;
  logic                  head_signed;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] extended;

  // Lane mapping of the incoming request
  always_comb begin
    logic [2:0] mask3;
    mask3 = 3'd0;
    be_base = 8'h00;
    case (req_size)
      2'd0: begin mask3 = 3'd0; be_base = 8'h01; end
      2'd1: begin mask3 = 3'd1; be_base = 8'h03; end
      2'd2: begin mask3 = 3'd3; be_base = 8'h0F; end
      default: begin mask3 = 3'd7; be_base = 8'hFF; end
    endcase
    size_mask  = mask3[OB-1:0];
    off_raw    = req_address[OB-1:0];
    off        = off_raw & ~size_mask;
    misaligned = |(off_raw & size_mask);
    be_shifted = {8'h00, be_base} << off;
  end

  // Each lane takes the right-aligned source byte it mirrors within the access size
  generate
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      logic [OB-1:0] lane_src;
      assign lane_src = OB'(gi) & size_mask;
      assign wdata_rep[8*gi +: 8] = req_writedata[8*lane_src +: 8];
    end
  endgenerate

  assign cmd_busy = read_reg | write_reg;
  assign full     = (count_reg == PW'(MAX_PENDING));
  assign pop      = avm.readdatavalid & (count_reg != '0);
  // A full FIFO still admits a load in the cycle a slot is freed by a return
  assign req_ready = ~reset & (~cmd_busy | ~avm.waitrequest) & ~(~req_write & full & ~pop);
  assign accept    = req_valid & req_ready;
  assign push      = accept & ~req_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_reg        <= '0;
      read_reg           <= 1'b0;
      write_reg          <= 1'b0;
      writedata_reg      <= '0;
      byteenable_reg     <= '0;
      err_misaligned_reg <= 1'b0;
    end else begin
      err_misaligned_reg <= accept & misaligned;
      if (accept) begin
        address_reg    <= {req_address[ADDR_WIDTH-1:OB], {OB{1'b0}}};
        read_reg       <= ~req_write;
        write_reg      <= req_write;
        writedata_reg  <= wdata_rep;
        byteenable_reg <= be_shifted[BE_WIDTH-1:0];
      end else if (!avm.waitrequest) begin
        read_reg  <= 1'b0;
        write_reg <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset; the pointers and count define its contents
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {off, req_size, req_signed};
    end
  end

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_signed = head[0];
  assign head_size   = head[2:1];
  assign head_off    = head[ENTRY_W-1:3];
  assign shifted     = avm.readdata >> {head_off, 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = shifted[DATA_WIDTH-1];
    case (head_size)
      2'd0: begin keep_mask = DATA_WIDTH'(8'hFF);         sign_bit = shifted[7];  end
      2'd1: begin keep_mask = DATA_WIDTH'(16'hFFFF);      sign_bit = shifted[15]; end
      2'd2: begin keep_mask = DATA_WIDTH'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1; sign_bit = shifted[DATA_WIDTH-1]; end
    endcase
    extended = (shifted & keep_mask) | ((head_signed & sign_bit) ? ~keep_mask : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      ignore_stray_reg <= 1'b1;
      err_protocol_reg <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_readdata_reg <= '0;
    end else begin
      rsp_valid_reg <= pop;
      if (push) begin
        wr_ptr_reg       <= wr_ptr_reg + 1'b1;
        ignore_stray_reg <= 1'b0;
      end
      if (pop) begin
        rd_ptr_reg       <= rd_ptr_reg + 1'b1;
        rsp_readdata_reg <= extended;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Returns after a reset belong to dropped loads until a new load is accepted
      if (avm.readdatavalid && count_reg == '0 && !ignore_stray_reg) begin
        err_protocol_reg <= 1'b1;
      end
    end
  end

  assign avm.address    = address_reg;
  assign avm.read       = read_reg;
  assign avm.write      = write_reg;
  assign avm.writedata  = writedata_reg;
  assign avm.byteenable = byteenable_reg;

  assign rsp_valid      = rsp_valid_reg;
  assign rsp_readdata   = rsp_readdata_reg;
  assign pending_count  = count_reg;
  assign err_misaligned = err_misaligned_reg;
  assign err_protocol   = err_protocol_reg;
endmodule
